// File: rtl/seg_scan_display_pkg.sv
// Shared constants for seg_scan_display: active-low segment patterns {g,f,e,d,c,b,a},
// the converter FSM state encoding and small constant helpers.
package seg_scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Largest value that fits in n decimal digits.
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, W steps per
// conversion; done is high during the cycle whose edge performs the final step.
module bin2bcd_seq #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  logic [BW+W-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   adj;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (sr_q[W+gi*4 +: 4] >= 4'd5) ? sr_q[W+gi*4 +: 4] + 4'd3
                                                           : sr_q[W+gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start) begin
      sr_d  = {{BW{1'b0}}, bin};
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      sr_d  = {adj, sr_q[W-1:0]} << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign bcd  = sr_q[BW+W-1:W];

endmodule

// File: rtl/seg_scan_display.sv
// Signed result -> BCD -> multiplexed common-anode 7-segment display, one digit per
// scan_clk rising edge. Define SEG_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_clk,
  input  logic              load,
  input  logic [W-1:0]      value,
  output logic              busy,
  output logic              neg,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int          BW    = 4 * DIGITS;
  localparam int          IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIMIT = pow10_minus1(DIGITS);

  state_t            state_q, state_d;
  logic              neg_n_q, neg_n_d, ovf_n_q, ovf_n_d;
  logic              neg_q, neg_d, ovf_q, ovf_d;
  logic [BW-1:0]     digits_q, digits_d;
  logic              scan_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [W-1:0]      mag;
  logic              too_big, start, conv_done, tick;
  logic [BW-1:0]     bcd;
  logic [3:0]        dig [DIGITS];
  logic [DIGITS-1:0] blank;

  // Two's-complement negate of the most-negative value yields 2^(W-1) as unsigned.
  assign mag     = value[W-1] ? -value : value;
  assign too_big = ({{(64-W){1'b0}}, mag} > LIMIT);
  assign tick    = scan_clk & ~scan_q;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d  = state_q;
    neg_n_d  = neg_n_q;
    ovf_n_d  = ovf_n_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    start    = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        neg_n_d = value[W-1];
        ovf_n_d = too_big;
        start   = ~too_big;
        state_d = too_big ? COMMIT : CONV;
      end
      CONV: if (conv_done) state_d = COMMIT;
      COMMIT: begin
        digits_d = ovf_n_q ? '0 : bcd;
        neg_d    = neg_n_q;
        ovf_d    = ovf_n_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign dig[gi] = digits_q[gi*4 +: 4];
    end
  endgenerate

`ifdef SEG_LZ_BLANK_EN
  logic seen_nz;
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen_nz  = seen_nz | (dig[i] != 4'd0);
      blank[i] = ~seen_nz;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = ovf_q ? SEG_DASH : (blank[idx_q] ? SEG_BLANK : seg_decode(dig[idx_q]));
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      neg_n_q  <= 1'b0;
      ovf_n_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      scan_q   <= 1'b0;
      idx_q    <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      neg_n_q  <= neg_n_d;
      ovf_n_q  <= ovf_n_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      scan_q   <= scan_clk;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign neg  = neg_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
